ability_cooldown_bank: RTL and testbench

Parametrised bank of N independent ability cooldown timers sharing one seconds prescaler. Each channel detects a rising edge on its trigger, emits a one-cycle fire pulse, and then blocks re-use for a programmed number of seconds. Countdown pauses while the game's master enable is low. The bank sits between the KEY inputs and the game-logic / seven-segment display path, replacing the per-ability fixed cooldown counters.

---
 rtl/ability_cooldown_bank_pkg.sv | 24 ++
 rtl/ability_cooldown_bank_if.sv | 26 ++
 rtl/ability_cooldown_bank_seconds_tick_gen.sv | 28 ++
 rtl/ability_cooldown_bank.sv | 148 ++++++++++++++
 tb/tb_ability_cooldown_bank.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/ability_cooldown_bank_pkg.sv
// Shared types and seven-segment constants for the ability cooldown bank.
package ability_pkg;

    typedef enum logic {
        CD_READY   = 1'b0,
        CD_COOLING = 1'b1
    } cd_state_t;

    localparam int CNT_W_DEF = 7;

    // Active-low segments ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    function automatic logic [6:0] seg_of_digit(input int d);
        if (d >= 0 && d <= 9) return SEG_DIGIT[d];
        return SEG_DASH;
    endfunction

endpackage

// File: rtl/ability_cooldown_bank_if.sv
// Bus between the game/KEY side (master) and the cooldown bank (slave).
interface ability_cooldown_bank_if #(
    parameter int NUM_ABILITIES = 2,
    parameter int CNT_W         = ability_pkg::CNT_W_DEF
);
    localparam int SEL_W = (NUM_ABILITIES > 1) ? $clog2(NUM_ABILITIES) : 1;

    logic                           masterEnable;
    logic [NUM_ABILITIES-1:0]       trigger;
    logic [SEL_W-1:0]               disp_sel;
    logic [NUM_ABILITIES-1:0]       ready;
    logic [NUM_ABILITIES-1:0]       fire;
    logic [NUM_ABILITIES*CNT_W-1:0] remaining;
    logic [6:0]                     hex_tens;
    logic [6:0]                     hex_ones;

    modport master (
        output masterEnable, trigger, disp_sel,
        input  ready, fire, remaining, hex_tens, hex_ones
    );

    modport slave (
        input  masterEnable, trigger, disp_sel,
        output ready, fire, remaining, hex_tens, hex_ones
    );
endinterface

// File: rtl/ability_cooldown_bank_seconds_tick_gen.sv
// Shared seconds prescaler: one-cycle tick every TICK_DIV enabled cycles, frozen while paused.
module seconds_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic masterEnable,
    output logic tick
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (masterEnable) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // Gated so a count parked on LAST during a pause does not keep ticking
    assign tick = masterEnable && (cnt_q == LAST);

endmodule

// File: rtl/ability_cooldown_bank.sv
// Bank of independent ability cooldown timers sharing one seconds prescaler.
// Define ABILITY_QUEUE_EN to queue one press made while a channel is cooling.
module ability_cooldown_bank
    import ability_pkg::*;
#(
    parameter int NUM_ABILITIES = 2,
    parameter int CNT_W         = CNT_W_DEF,
    parameter int TICK_DIV      = 50_000_000,
    parameter logic [NUM_ABILITIES*CNT_W-1:0] COOLDOWN_SEC = {7'd10, 7'd5}
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    ability_cooldown_bank_if.slave bus
);
    logic                           tick;
    logic [NUM_ABILITIES-1:0]       trig_q;
    logic [NUM_ABILITIES-1:0]       trig_edge;
    logic [NUM_ABILITIES-1:0]       ready_vec;
    logic [NUM_ABILITIES-1:0]       fire_vec;
    logic [NUM_ABILITIES*CNT_W-1:0] remaining_vec;

    seconds_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .masterEnable (bus.masterEnable),
        .tick         (tick)
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) trig_q <= '0;
        else       trig_q <= bus.trigger;
    end

    assign trig_edge = bus.trigger & ~trig_q;

    for (genvar gi = 0; gi < NUM_ABILITIES; gi++) begin : g_ch
        localparam logic [CNT_W-1:0] RELOAD = COOLDOWN_SEC[gi*CNT_W +: CNT_W];

        cd_state_t        state_q, state_d;
        logic [CNT_W-1:0] remain_q, remain_d;
        logic             fire_q, fire_d;
        logic             ready_q;
        logic             press;

        assign press = trig_edge[gi] && bus.masterEnable;
`ifdef ABILITY_QUEUE_EN
        logic pend_q, pend_d;
`endif

        always_comb begin
            state_d  = state_q;
            remain_d = remain_q;
            fire_d   = 1'b0;
`ifdef ABILITY_QUEUE_EN
            pend_d   = pend_q;
`endif
            case (state_q)
                CD_READY: begin
                    // A fresh press wins over a coincident tick: full reload, no decrement
                    if (press) begin
                        fire_d   = 1'b1;
                        remain_d = RELOAD;
                        if (RELOAD != '0) state_d = CD_COOLING;
                    end
                end
                CD_COOLING: begin
`ifdef ABILITY_QUEUE_EN
                    if (press) pend_d = 1'b1;
`endif
                    if (tick) begin
                        if (remain_q == CNT_W'(1)) begin
`ifdef ABILITY_QUEUE_EN
                            if (pend_q || press) begin
                                fire_d   = 1'b1;
                                remain_d = RELOAD;
                                pend_d   = 1'b0;
                            end else begin
                                state_d  = CD_READY;
                                remain_d = '0;
                            end
`else
                            state_d  = CD_READY;
                            remain_d = '0;
`endif
                        end else begin
                            remain_d = remain_q - 1'b1;
                        end
                    end
                end
                default: state_d = CD_READY;
            endcase
        end

        always_ff @(posedge CLOCK_50 or posedge reset) begin
            if (reset) begin
                state_q  <= CD_READY;
                remain_q <= '0;
                fire_q   <= 1'b0;
                ready_q  <= 1'b1;
`ifdef ABILITY_QUEUE_EN
                pend_q   <= 1'b0;
`endif
            end else begin
                state_q  <= state_d;
                remain_q <= remain_d;
                fire_q   <= fire_d;
                ready_q  <= (state_d == CD_READY);
`ifdef ABILITY_QUEUE_EN
                pend_q   <= pend_d;
`endif
            end
        end

        assign ready_vec[gi]                     = ready_q;
        assign fire_vec[gi]                      = fire_q;
        assign remaining_vec[gi*CNT_W +: CNT_W] = remain_q;
    end

    assign bus.ready     = ready_vec;
    assign bus.fire      = fire_vec;
    assign bus.remaining = remaining_vec;

    logic [CNT_W-1:0] sel_val;
    logic             sel_ok;

    always_comb begin
        sel_val      = '0;
        sel_ok       = 1'b0;
        bus.hex_tens = SEG_BLANK;
        bus.hex_ones = SEG_BLANK;
        for (int i = 0; i < NUM_ABILITIES; i++) begin
            if (int'(bus.disp_sel) == i) begin
                sel_val = remaining_vec[i*CNT_W +: CNT_W];
                sel_ok  = 1'b1;
            end
        end
        if (sel_ok) begin
            if (int'(sel_val) > 99) begin
                bus.hex_tens = SEG_DASH;
                bus.hex_ones = SEG_DASH;
            end else begin
                bus.hex_tens = seg_of_digit(int'(sel_val) / 10);
                bus.hex_ones = seg_of_digit(int'(sel_val) % 10);
            end
        end
    end

endmodule

// File: tb/tb_ability_cooldown_bank.sv
// Directed bench for ability_cooldown_bank (TICK_DIV=4, main bank {5,3}, second bank {5,0}).
module tb_ability_cooldown_bank;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ability_cooldown_bank_if #(.NUM_ABILITIES(2), .CNT_W(7)) bus   ();
    ability_cooldown_bank_if #(.NUM_ABILITIES(2), .CNT_W(7)) bus_z ();

    ability_cooldown_bank #(
        .NUM_ABILITIES (2),
        .CNT_W         (7),
        .TICK_DIV      (4),
        .COOLDOWN_SEC  ({7'd5, 7'd3})
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus)
    );

    ability_cooldown_bank #(
        .NUM_ABILITIES (2),
        .CNT_W         (7),
        .TICK_DIV      (4),
        .COOLDOWN_SEC  ({7'd5, 7'd0})
    ) dut_z (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus_z)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int ph       = 0;
    logic tick_exp;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Advance one clock; tick_exp tracks whether the shared prescaler ticked at that edge
    task automatic step();
        tick_exp = bus.masterEnable && (ph == 3);
        @(posedge clk);
        if (bus.masterEnable) ph = (ph + 1) % 4;
        #1;
    endtask

    int n, fires, en_cnt;
    logic rose;
    logic [6:0] exp_rem;

    initial begin
        rst = 1'b1;
        bus.masterEnable   = 1'b0; bus.trigger   = '0; bus.disp_sel   = '0;
        bus_z.masterEnable = 1'b0; bus_z.trigger = '0; bus_z.disp_sel = '0;
        step(); step();
        check_val("rst_ready",     bus.ready, 2'b11);
        check_val("rst_fire",      bus.fire, 2'b00);
        check_val("rst_remaining", bus.remaining, 14'd0);
        check_val("rst_hex_tens",  bus.hex_tens, 7'b1000000);
        check_val("rst_hex_ones",  bus.hex_ones, 7'b1000000);
        rst = 1'b0; ph = 0;
        bus.masterEnable = 1'b1; bus_z.masterEnable = 1'b1;
        step();

        // T1: single pulse on channel 0
        bus.trigger = 2'b01;
        step();
        bus.trigger = 2'b00;
        check_val("t1_fire",      bus.fire, 2'b01);
        check_val("t1_ready",     bus.ready, 2'b10);
        check_val("t1_remaining", bus.remaining[6:0], 7'd3);
        check_val("t1_hex_tens",  bus.hex_tens, 7'b1000000);
        check_val("t1_hex_ones",  bus.hex_ones, 7'b0110000);
        n = 0; fires = 0;
        for (int i = 0; i < 20 && !bus.ready[0]; i++) begin
            step(); n++;
            if (bus.fire[0]) fires++;
        end
        check_val("t1_ready_back", bus.ready[0], 1'b1);
        check_val("t1_dur_in_9_12", (n >= 9 && n <= 12), 1'b1);
        check_val("t1_no_refire", fires, 0);
        $display("t1 pulse: cooldown took %0d cycles", n);

        // T2: held trigger on channel 1
        bus.trigger = 2'b10; bus.disp_sel = 1'b1;
        step();
        check_val("t2_fire",     bus.fire, 2'b10);
        check_val("t2_remaining", bus.remaining[13:7], 7'd5);
        check_val("t2_hex_tens", bus.hex_tens, 7'b1000000);
        check_val("t2_hex_ones", bus.hex_ones, 7'b0010010);
        fires = 1;
        for (int i = 1; i < 40; i++) begin
            step();
            if (bus.fire[1]) fires++;
        end
        bus.trigger = 2'b00; bus.disp_sel = 1'b0;
        check_val("t2_one_fire", fires, 1);
        check_val("t2_ready",    bus.ready[1], 1'b1);
        $display("t2 held trigger: %0d fire pulses", fires);
        step();

        // T3: pause mid-cooldown
        bus.trigger = 2'b01;
        step();
        bus.trigger = 2'b00;
        check_val("t3_fire", bus.fire[0], 1'b1);
        exp_rem = 7'd3; en_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            step(); en_cnt++;
            if (tick_exp) exp_rem = exp_rem - 7'd1;
        end
        check_val("t3_pre_pause_rem", bus.remaining[6:0], exp_rem);
        bus.masterEnable = 1'b0;
        fires = 0;
        for (int i = 0; i < 100; i++) begin
            bus.trigger = (i == 10) ? 2'b10 : 2'b00;
            step();
            if (bus.fire != 2'b00) fires++;
        end
        bus.trigger = 2'b00;
        check_val("t3_frozen_rem",   bus.remaining[6:0], exp_rem);
        check_val("t3_paused_ready", bus.ready[0], 1'b0);
        check_val("t3_paused_edge_ignored", fires, 0);
        bus.masterEnable = 1'b1;
        for (int i = 0; i < 30 && !bus.ready[0]; i++) begin
            step(); en_cnt++;
        end
        check_val("t3_ready_back", bus.ready[0], 1'b1);
        check_val("t3_enabled_dur_in_9_12", (en_cnt >= 9 && en_cnt <= 12), 1'b1);
        $display("t3 pause: %0d enabled cycles of cooldown", en_cnt);

        // T4: press while cooling
        bus.trigger = 2'b01;
        step();
        bus.trigger = 2'b00;
        check_val("t4_fire", bus.fire[0], 1'b1);
        step(); step();
        bus.trigger = 2'b01;
        step();
        bus.trigger = 2'b00;
        check_val("t4_press_no_fire", bus.fire[0], 1'b0);
        fires = 0; rose = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.fire[0]) fires++;
            if (bus.ready[0] && fires == 0) rose = 1'b1;
        end
`ifdef ABILITY_QUEUE_EN
        check_val("t4_queued_fire", fires, 1);
        check_val("t4_no_ready_gap", rose, 1'b0);
`else
        check_val("t4_dropped_press", fires, 0);
        check_val("t4_ready_rose", rose, 1'b1);
`endif
        check_val("t4_final_ready", bus.ready[0], 1'b1);
        $display("t4 press while cooling: %0d extra fires", fires);

        // T5: reset mid-cooldown
        bus.trigger = 2'b10;
        step();
        bus.trigger = 2'b00;
        check_val("t5_fire", bus.fire[1], 1'b1);
        step(); step();
        bus.disp_sel = 1'b1;
        rst = 1'b1;
        #2;
        check_val("t5_async_ready", bus.ready, 2'b11);
        step();
        check_val("t5_ready",     bus.ready, 2'b11);
        check_val("t5_remaining", bus.remaining, 14'd0);
        check_val("t5_fire_low",  bus.fire, 2'b00);
        check_val("t5_hex_tens",  bus.hex_tens, 7'b1000000);
        check_val("t5_hex_ones",  bus.hex_ones, 7'b1000000);
        rst = 1'b0; ph = 0;
        bus.disp_sel = 1'b0;
        $display("t5 reset mid-cooldown done");

        // T6: zero-cooldown channel on the second bank
        step();
        bus_z.trigger = 2'b01;
        step();
        bus_z.trigger = 2'b00;
        check_val("t6_zero_fire",  bus_z.fire, 2'b01);
        check_val("t6_zero_ready", bus_z.ready, 2'b11);
        check_val("t6_zero_rem",   bus_z.remaining[6:0], 7'd0);
        bus_z.trigger = 2'b10; bus_z.disp_sel = 1'b1;
        step();
        bus_z.trigger = 2'b01;
        check_val("t6_ch1_fire",     bus_z.fire, 2'b10);
        check_val("t6_ch1_ready",    bus_z.ready, 2'b01);
        check_val("t6_ch1_rem",      bus_z.remaining[13:7], 7'd5);
        check_val("t6_ch1_hex_tens", bus_z.hex_tens, 7'b1000000);
        check_val("t6_ch1_hex_ones", bus_z.hex_ones, 7'b0010010);
        step();
        bus_z.trigger = 2'b00;
        check_val("t6_zero_refire", bus_z.fire, 2'b01);
        $display("t6 zero-cooldown channel done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
